tempo_controller: RTL and testbench

Converts decoded rotary-wheel activity into a bounded note-duration value and a periodic beat strobe for the music playback path. Sits between the rotary decoder / pushbutton edge detector and the music streamer. Rotating the wheel speeds up or slows down playback, with acceleration on fast spins. The rotary push button restores the default tempo. `beat_tick` tells the streamer when to advance to the next note.

---
 rtl/tempo_controller.sv | 124 ++++++++++++
 tb/tb_tempo_controller.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tempo_controller.sv
// tempo_controller
// Turns rotary-wheel detents and push-button presses into a clamped beat
// period, and runs a beat counter that strobes beat_tick once per period
// while enabled. Closely spaced detents use a 4x step so fast spins cover
// the tempo range quickly.
module tempo_controller #(
    parameter logic [23:0] DEFAULT_PERIOD = 24'd8_250_000,
    parameter logic [23:0] MIN_PERIOD     = 24'd1_650_000,
    parameter logic [23:0] MAX_PERIOD     = 24'd33_000_000,
    parameter logic [23:0] STEP           = 24'd165_000,
    parameter logic [23:0] FAST_WINDOW    = 24'd1_650_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rotary_event,
    input  logic        rotary_left,
    input  logic        rotary_push,
    input  logic        enable,
    output logic [23:0] beat_period,
    output logic        beat_tick,
    output logic        fast_mode
);

    // Accelerated step; parameters guarantee it still fits in 24 bits.
    localparam logic [23:0] STEP_FAST = STEP << 2;

    // Slowing down: the sum can only overshoot the upper bound.
    function automatic logic [23:0] clamp_up(input logic [24:0] value);
        if (value > {1'b0, MAX_PERIOD}) begin
            return MAX_PERIOD;
        end
        return value[23:0];
    endfunction

    // Speeding up: a negative difference or one below the floor pins at MIN.
    function automatic logic [23:0] clamp_down(input logic signed [24:0] value);
        if (value < 25'sd0) begin
            return MIN_PERIOD;
        end
        if (value[23:0] < MIN_PERIOD) begin
            return MIN_PERIOD;
        end
        return value[23:0];
    endfunction

    logic [23:0]        gap_count;
    logic [23:0]        gap_inc;
    logic               gap_fast;
    logic               gap_reaching_window;
    logic [23:0]        step_size;
    logic [24:0]        period_sum;
    logic signed [24:0] period_diff;
    logic [23:0]        period_next;
    logic               fast_next;
    logic [23:0]        beat_count;
    logic [23:0]        beat_limit;
    logic               beat_wrap;

    assign gap_inc             = gap_count + 24'd1;
    assign gap_fast            = (gap_count < FAST_WINDOW);
    assign gap_reaching_window = gap_fast && (gap_inc == FAST_WINDOW);

    // Period/fast-mode next-state: push overrides any simultaneous detent.
    always_comb begin
        step_size   = gap_fast ? STEP_FAST : STEP;
        period_sum  = {1'b0, beat_period} + {1'b0, step_size};
        period_diff = $signed({1'b0, beat_period}) - $signed({1'b0, step_size});
        period_next = beat_period;
        fast_next   = fast_mode;
        if (rotary_push) begin
            period_next = DEFAULT_PERIOD;
            fast_next   = 1'b0;
        end else if (rotary_event) begin
            period_next = rotary_left ? clamp_up(period_sum) : clamp_down(period_diff);
            fast_next   = gap_fast;
        end else if (gap_reaching_window) begin
            fast_next   = 1'b0;
        end
    end

    // Gap counter: cycles since the last detent or push, saturating at the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_count <= FAST_WINDOW;
        end else if (rotary_push || rotary_event) begin
            gap_count <= '0;
        end else if (gap_fast) begin
            gap_count <= gap_inc;
        end
    end

    // Registered tempo state.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_period <= DEFAULT_PERIOD;
            fast_mode   <= 1'b0;
        end else begin
            beat_period <= period_next;
            fast_mode   <= fast_next;
        end
    end

    // Wrap compare uses >= so a period that shrinks under the count wraps at once.
    assign beat_limit = beat_period - 24'd1;
    assign beat_wrap  = (beat_count >= beat_limit);

    // Beat counter and tick strobe; held idle while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_count <= '0;
            beat_tick  <= 1'b0;
        end else if (!enable) begin
            beat_count <= '0;
            beat_tick  <= 1'b0;
        end else if (beat_wrap) begin
            beat_count <= '0;
            beat_tick  <= 1'b1;
        end else begin
            beat_count <= beat_count + 24'd1;
            beat_tick  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tempo_controller.sv
// Testbench for tempo_controller with small parameters (period 20, range 8..40,
// step 2, fast window 10). A cycle-level behavioural model predicts the outputs
// and is compared every cycle; directed literal checks pin the model.
module tb_tempo_controller;

    localparam int DEF = 20;
    localparam int MINP = 8;
    localparam int MAXP = 40;
    localparam int STP = 2;
    localparam int FW = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        rotary_event;
    logic        rotary_left;
    logic        rotary_push;
    logic        enable;
    logic [23:0] beat_period;
    logic        beat_tick;
    logic        fast_mode;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    tempo_controller #(
        .DEFAULT_PERIOD(24'(DEF)),
        .MIN_PERIOD    (24'(MINP)),
        .MAX_PERIOD    (24'(MAXP)),
        .STEP          (24'(STP)),
        .FAST_WINDOW   (24'(FW))
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rotary_event(rotary_event),
        .rotary_left (rotary_left),
        .rotary_push (rotary_push),
        .enable      (enable),
        .beat_period (beat_period),
        .beat_tick   (beat_tick),
        .fast_mode   (fast_mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Behavioural model: the gap is the distance in cycles to the last
    // detent/push, a beat starts at a known cycle and ticks when its age
    // reaches period-1, fast mode lasts while the last detent was fast and
    // the gap is still inside the window.
    int m_period;
    int m_start;
    int m_zero;
    bit m_has_zero;
    bit m_evt_fast;
    bit m_tick;
    bit m_fast;
    bit m_valid = 1'b0;

    function automatic int gap_at(input int t);
        if (!m_has_zero) return FW;
        if (t - m_zero - 1 >= FW) return FW;
        return t - m_zero - 1;
    endfunction

    always @(posedge clk) begin : model
        int t;
        int g;
        int step;
        int np;
        t = cyc;
        if (rst) begin
            m_period   = DEF;
            m_has_zero = 1'b0;
            m_evt_fast = 1'b0;
            m_tick     = 1'b0;
            m_start    = t + 1;
            m_valid    = 1'b1;
        end else begin
            if (!enable) begin
                m_tick  = 1'b0;
                m_start = t + 1;
            end else if (t - m_start >= m_period - 1) begin
                m_tick  = 1'b1;
                m_start = t + 1;
            end else begin
                m_tick  = 1'b0;
            end
            g = gap_at(t);
            if (rotary_push) begin
                m_period   = DEF;
                m_has_zero = 1'b1;
                m_zero     = t;
                m_evt_fast = 1'b0;
            end else if (rotary_event) begin
                m_evt_fast = (g < FW);
                step = m_evt_fast ? 4 * STP : STP;
                np = rotary_left ? m_period + step : m_period - step;
                if (np > MAXP) np = MAXP;
                if (np < MINP) np = MINP;
                m_period   = np;
                m_has_zero = 1'b1;
                m_zero     = t;
            end
        end
        m_fast = m_evt_fast && (gap_at(t + 1) < FW);
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_period", 32'(beat_period), 32'(m_period));
            chk("model_tick", 32'(beat_tick), 32'(m_tick));
            chk("model_fast", 32'(fast_mode), 32'(m_fast));
        end
    end

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at(input int c);
        go_to(c);
        @(negedge clk);
    endtask

    task automatic pulse(input int c, input logic left, input logic push, input logic ev);
        go_to(c);
        rotary_event = ev;
        rotary_left  = left;
        rotary_push  = push;
        go_to(c + 1);
        rotary_event = 1'b0;
        rotary_push  = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rotary_event = 1'b0;
        rotary_left = 1'b0;
        rotary_push = 1'b0;
        enable = 1'b0;

        // Reset then enable at cycle 3: ticks at 23, 43, 63
        go_to(3);
        rst = 1'b0;
        enable = 1'b1;
        at(3);
        chk("reset_period", 32'(beat_period), 32'd20);
        chk("reset_tick", 32'(beat_tick), 32'd0);
        chk("reset_fast", 32'(fast_mode), 32'd0);
        at(22);
        chk("first_tick_early", 32'(beat_tick), 32'd0);
        at(23);
        chk("first_tick", 32'(beat_tick), 32'd1);
        at(43);
        chk("second_tick", 32'(beat_tick), 32'd1);
        at(63);
        chk("third_tick", 32'(beat_tick), 32'd1);
        chk("idle_period", 32'(beat_period), 32'd20);
        chk("idle_fast", 32'(fast_mode), 32'd0);

        // Acceleration
        pulse(70, 1'b0, 1'b0, 1'b1);
        at(71);
        chk("slow_right_period", 32'(beat_period), 32'd18);
        chk("slow_right_fast", 32'(fast_mode), 32'd0);
        pulse(75, 1'b0, 1'b0, 1'b1);
        at(76);
        chk("fast_right_period", 32'(beat_period), 32'd10);
        chk("fast_right_fast", 32'(fast_mode), 32'd1);
        pulse(80, 1'b0, 1'b0, 1'b1);
        at(81);
        chk("fast_right_floor", 32'(beat_period), 32'd8);
        chk("fast_right_floor_fast", 32'(fast_mode), 32'd1);
        at(95);
        chk("fast_timeout", 32'(fast_mode), 32'd0);

        // Clamp at the floor with slow right detents
        pulse(96, 1'b0, 1'b1, 1'b0);
        at(97);
        chk("push_restore", 32'(beat_period), 32'd20);
        for (int k = 0; k < 15; k++) begin
            pulse(110 + 12 * k, 1'b0, 1'b0, 1'b1);
            if (k == 5) begin
                at(171);
                chk("floor_reached", 32'(beat_period), 32'd8);
            end
        end
        at(279);
        chk("floor_held", 32'(beat_period), 32'd8);
        chk("floor_slow", 32'(fast_mode), 32'd0);

        // Clamp at the ceiling with fast left detents
        pulse(290, 1'b1, 1'b0, 1'b1);
        pulse(293, 1'b1, 1'b0, 1'b1);
        pulse(296, 1'b1, 1'b0, 1'b1);
        pulse(299, 1'b1, 1'b0, 1'b1);
        pulse(302, 1'b1, 1'b0, 1'b1);
        at(303);
        chk("ceiling_reached", 32'(beat_period), 32'd40);
        pulse(305, 1'b1, 1'b0, 1'b1);
        at(306);
        chk("ceiling_held", 32'(beat_period), 32'd40);
        chk("ceiling_fast", 32'(fast_mode), 32'd1);

        // Push wins over a simultaneous detent
        pulse(320, 1'b0, 1'b0, 1'b1);
        pulse(323, 1'b0, 1'b0, 1'b1);
        at(324);
        chk("setup_30", 32'(beat_period), 32'd30);
        pulse(326, 1'b1, 1'b1, 1'b1);
        at(327);
        chk("push_priority_period", 32'(beat_period), 32'd20);
        chk("push_priority_fast", 32'(fast_mode), 32'd0);
        pulse(340, 1'b1, 1'b0, 1'b1);
        at(341);
        chk("after_push_left", 32'(beat_period), 32'd22);
        chk("after_push_fast", 32'(fast_mode), 32'd0);

        // Period shrinks below the running count
        go_to(360);
        enable = 1'b0;
        go_to(361);
        enable = 1'b1;
        pulse(373, 1'b0, 1'b1, 1'b0);
        pulse(376, 1'b0, 1'b0, 1'b1);
        at(377);
        chk("shrink_period", 32'(beat_period), 32'd12);
        chk("shrink_no_tick_yet", 32'(beat_tick), 32'd0);
        at(378);
        chk("shrink_tick", 32'(beat_tick), 32'd1);
        at(389);
        chk("shrink_gap", 32'(beat_tick), 32'd0);
        at(390);
        chk("shrink_tick2", 32'(beat_tick), 32'd1);
        at(402);
        chk("shrink_tick3", 32'(beat_tick), 32'd1);

        // Reset mid-beat
        go_to(410);
        enable = 1'b0;
        go_to(411);
        enable = 1'b1;
        pulse(415, 1'b1, 1'b0, 1'b1);
        pulse(418, 1'b1, 1'b0, 1'b1);
        pulse(421, 1'b1, 1'b0, 1'b1);
        at(424);
        chk("midbeat_period", 32'(beat_period), 32'd30);
        chk("midbeat_fast", 32'(fast_mode), 32'd1);
        go_to(424);
        rst = 1'b1;
        go_to(425);
        rst = 1'b0;
        at(425);
        chk("rst_mid_period", 32'(beat_period), 32'd20);
        chk("rst_mid_fast", 32'(fast_mode), 32'd0);
        chk("rst_mid_tick", 32'(beat_tick), 32'd0);
        at(444);
        chk("rst_mid_early", 32'(beat_tick), 32'd0);
        at(445);
        chk("rst_mid_tick_after", 32'(beat_tick), 32'd1);

        at(450);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
